// File: rtl/operand_fetch.sv
// operand_fetch
//   Decode-side operand fetch stage. Drives the two register-file read
//   channels, resolves each source operand (EX forward > MEM forward >
//   register file; r0 always reads 0), stalls on load-use hazards and
//   registers the resolved operands into a ready/valid stage feeding EX.
//
// Ports
//   clk, rst (sync, active-low), flush
//   in_*       : decoded instruction fields with valid/ready handshake
//   read_*     : register-file read channels (combinational)
//   ex_fwd_*   : EX stage forward (loads are not forwardable from EX)
//   mem_fwd_*  : MEM stage forward
//   out_*      : registered operands with valid/ready handshake
//   stall_cycles : saturating count of load-use stall cycles
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs_addr,
  input  logic [4:0]  in_rt_addr,
  input  logic        in_rs_en,
  input  logic        in_rt_en,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic [4:0]  in_dest_addr,
  input  logic        in_dest_en,
  input  logic        in_is_load,
  output logic        read_en_1,
  output logic        read_en_2,
  output logic [4:0]  read_addr_1,
  output logic [4:0]  read_addr_2,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  input  logic        ex_fwd_en,
  input  logic        ex_fwd_is_load,
  input  logic [4:0]  ex_fwd_addr,
  input  logic [31:0] ex_fwd_data,
  input  logic        mem_fwd_en,
  input  logic [4:0]  mem_fwd_addr,
  input  logic [31:0] mem_fwd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op_a,
  output logic [31:0] out_op_b,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_dest_addr,
  output logic        out_dest_en,
  output logic        out_is_load,
  output logic [31:0] stall_cycles
);

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hazard;
  logic        capture;

  function automatic logic [31:0] resolve(
    input logic [4:0]  s,
    input logic        e,
    input logic [31:0] rf_data,
    input logic        ex_en,
    input logic        ex_load,
    input logic [4:0]  ex_addr,
    input logic [31:0] ex_data,
    input logic        mem_en,
    input logic [4:0]  mem_addr,
    input logic [31:0] mem_data
  );
    if (!e || s == 5'd0)                          return '0;
    else if (ex_en && ex_addr == s && !ex_load)   return ex_data;
    else if (mem_en && mem_addr == s)             return mem_data;
    else                                          return rf_data;
  endfunction

  always_comb begin
    read_en_1   = in_valid & in_rs_en;
    read_addr_1 = in_rs_addr;
    read_en_2   = in_valid & in_rt_en;
    read_addr_2 = in_rt_addr;

    rs_val = resolve(in_rs_addr, in_rs_en, read_data_1, ex_fwd_en, ex_fwd_is_load,
                     ex_fwd_addr, ex_fwd_data, mem_fwd_en, mem_fwd_addr, mem_fwd_data);
    rt_val = resolve(in_rt_addr, in_rt_en, read_data_2, ex_fwd_en, ex_fwd_is_load,
                     ex_fwd_addr, ex_fwd_data, mem_fwd_en, mem_fwd_addr, mem_fwd_data);

    // A load in EX has no data yet; any consumer of its destination waits
    // one cycle and then picks it up from the MEM forward.
    hazard = in_valid & ex_fwd_en & ex_fwd_is_load & (ex_fwd_addr != 5'd0) &
             ((in_rs_en & (ex_fwd_addr == in_rs_addr)) |
              (in_rt_en & (ex_fwd_addr == in_rt_addr)));

    in_ready = !flush & !hazard & (!out_valid | out_ready);
    capture  = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      out_op_a       <= '0;
      out_op_b       <= '0;
      out_store_data <= '0;
      out_dest_addr  <= '0;
      out_dest_en    <= 1'b0;
      out_is_load    <= 1'b0;
      stall_cycles   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid      <= 1'b1;
        out_op_a       <= rs_val;
        out_op_b       <= in_use_imm ? in_imm : rt_val;
        out_store_data <= rt_val;
        out_dest_addr  <= in_dest_addr;
        out_dest_en    <= in_dest_en;
        out_is_load    <= in_is_load;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (hazard && !flush && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
